// File: rtl/univ_shift_reg.sv
// univ_shift_reg: parametrised universal register with a single-bit-per-clock
// shifter. Hold, load and clear complete at the start edge. Shifts and rotates
// run amt steps under a start/busy/done handshake.
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous active-high reset, also aborts a running shift
//   start_i  operation request, sampled only while idle
//   op_i     operation code (NOP/LOAD/CLEAR/SHL/SHR/ROL/ROR/ASR)
//   d_i      parallel load data
//   amt_i    number of single-bit steps for shift/rotate ops
//   sin_i    serial input for SHL/SHR, sampled on every step edge
//   q_o      register contents
//   busy_o   high while a multi-step shift is running
//   done_o   one-cycle completion pulse
//   sout_o   last bit shifted or rotated out
//
// state | meaning
// IDLE  | waiting for start, busy low
// RUN   | applying one step of the latched op per clock, busy high

module univ_shift_reg #(
  parameter int                WIDTH   = 8,
  parameter int                AMT_W   = 4,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [2:0]        op_i,
  input  logic [WIDTH-1:0]  d_i,
  input  logic [AMT_W-1:0]  amt_i,
  input  logic              sin_i,
  output logic [WIDTH-1:0]  q_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              sout_o
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_CLEAR = 3'b010;
  localparam logic [2:0] OP_SHL   = 3'b011;
  localparam logic [2:0] OP_SHR   = 3'b100;
  localparam logic [2:0] OP_ROL   = 3'b101;
  localparam logic [2:0] OP_ROR   = 3'b110;
  localparam logic [2:0] OP_ASR   = 3'b111;

  logic [0:0]       state_q, state_d;
  logic [AMT_W-1:0] cnt_q,   cnt_d;
  logic [2:0]       op_q,    op_d;
  logic [WIDTH-1:0] q_q,     q_d;
  logic             sout_q,  sout_d;
  logic             done_q,  done_d;

  // One step of the latched op, with the bit that leaves the register.
  logic [WIDTH-1:0] step_q;
  logic             step_out;

  always_comb begin
    step_q   = q_q;
    step_out = sout_q;
    case (op_q)
      OP_SHL: begin step_q = {q_q[WIDTH-2:0], sin_i};        step_out = q_q[WIDTH-1]; end
      OP_SHR: begin step_q = {sin_i, q_q[WIDTH-1:1]};        step_out = q_q[0];       end
      OP_ROL: begin step_q = {q_q[WIDTH-2:0], q_q[WIDTH-1]}; step_out = q_q[WIDTH-1]; end
      OP_ROR: begin step_q = {q_q[0], q_q[WIDTH-1:1]};       step_out = q_q[0];       end
      OP_ASR: begin step_q = {q_q[WIDTH-1], q_q[WIDTH-1:1]}; step_out = q_q[0];       end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    q_d     = q_q;
    sout_d  = sout_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          case (op_i)
            OP_NOP:   done_d = 1'b1;
            OP_LOAD:  begin q_d = d_i; done_d = 1'b1; end
            OP_CLEAR: begin q_d = '0;  done_d = 1'b1; end
            default: begin
              if (amt_i == '0) begin
                done_d = 1'b1;
              end else begin
                op_d    = op_i;
                cnt_d   = amt_i;
                state_d = S_RUN;
              end
            end
          endcase
        end
      end
      default: begin
        q_d    = step_q;
        sout_d = step_out;
        cnt_d  = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_NOP;
      q_q     <= RST_VAL;
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      q_q     <= q_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
    end
  end

  assign q_o    = q_q;
  assign busy_o = (state_q == S_RUN);
  assign done_o = done_q;
  assign sout_o = sout_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_i = 1'b0;
  logic [2:0] op_i = 3'd0;
  logic [7:0] d_i = 8'd0;
  logic [3:0] amt_i = 4'd0;
  logic       sin_i = 1'b0;
  logic [7:0] q_o;
  logic       busy_o, done_o, sout_o;

  int n_tests = 0;
  int n_fail  = 0;

  univ_shift_reg #(.WIDTH(8), .AMT_W(4), .RST_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .d_i(d_i),
    .amt_i(amt_i), .sin_i(sin_i), .q_o(q_o), .busy_o(busy_o),
    .done_o(done_o), .sout_o(sout_o)
  );

  always #5 clk = ~clk;

  // Reference model: remaining step count plus arithmetic on the value.
  logic [7:0] m_q    = 8'h00;
  logic       m_sout = 1'b0;
  logic       m_done = 1'b0;
  int         m_rem  = 0;
  logic [2:0] m_op   = 3'd0;

  function automatic logic [8:0] mstep(input logic [2:0] op, input logic [7:0] v,
                                       input logic s, input logic so);
    case (op)
      3'd3: return {v[7], 8'((v << 1) | 8'(s))};
      3'd4: return {v[0], 8'((v >> 1) | (8'(s) << 7))};
      3'd5: return {v[7], 8'((v << 1) | (v >> 7))};
      3'd6: return {v[0], 8'((v >> 1) | (v << 7))};
      3'd7: return {v[0], 8'($signed(v) >>> 1)};
      default: return {so, v};
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q <= 8'h00; m_sout <= 1'b0; m_done <= 1'b0; m_rem <= 0; m_op <= 3'd0;
    end else begin
      m_done <= 1'b0;
      if (m_rem == 0) begin
        if (start_i) begin
          if (op_i == 3'd0) m_done <= 1'b1;
          else if (op_i == 3'd1) begin m_q <= d_i; m_done <= 1'b1; end
          else if (op_i == 3'd2) begin m_q <= 8'h00; m_done <= 1'b1; end
          else if (amt_i == 4'd0) m_done <= 1'b1;
          else begin m_rem <= int'(amt_i); m_op <= op_i; end
        end
      end else begin
        {m_sout, m_q} <= mstep(m_op, m_q, sin_i, m_sout);
        m_rem <= m_rem - 1;
        if (m_rem == 1) m_done <= 1'b1;
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (!rst) begin
      n_tests++;
      if (q_o !== m_q || busy_o !== (m_rem != 0) || done_o !== m_done ||
          sout_o !== m_sout || (busy_o && done_o)) begin
        n_fail++;
        $display("FAIL cycle t=%0t: got q=%h busy=%b done=%b sout=%b, expected q=%h busy=%b done=%b sout=%b",
                 $time, q_o, busy_o, done_o, sout_o, m_q, (m_rem != 0), m_done, m_sout);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request and wait for done. With noise, the inputs are
  // scrambled every busy cycle (including start) to show they are ignored.
  task automatic do_op(input logic [2:0] op, input logic [7:0] d, input logic [3:0] amt,
                       input logic sin, input bit noise, output int busy_cyc);
    int cyc;
    busy_cyc = 0;
    @(negedge clk);
    start_i = 1'b1; op_i = op; d_i = d; amt_i = amt; sin_i = sin;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (busy_o) busy_cyc++;
      if (done_o) break;
      if (cyc > 40) begin
        chk("done_timeout", 32'(cyc), 32'd0);
        break;
      end
      if (noise) begin
        start_i = 1'($urandom_range(0, 1));
        op_i = 3'($urandom); d_i = 8'($urandom); amt_i = 4'($urandom);
        sin_i = 1'($urandom_range(0, 1));
      end else begin
        start_i = 1'b0;
      end
    end
    start_i = 1'b0;
  endtask

  int bc;

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_q", 32'(q_o), 32'h00);
    chk("reset_busy", 32'(busy_o), 32'd0);

    // Asynchronous reset from 0x3C, between clock edges.
    do_op(3'd1, 8'h3C, 4'd0, 1'b0, 1'b0, bc);
    chk("load_3c", 32'(q_o), 32'h3C);
    @(posedge clk); #2;
    rst = 1'b1; #1;
    chk("async_rst_q", 32'(q_o), 32'h00);
    chk("async_rst_flags", {29'd0, busy_o, done_o, sout_o}, 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_hold", 32'(q_o), 32'h00);

    // LOAD then NOP.
    do_op(3'd1, 8'hA5, 4'd0, 1'b0, 1'b0, bc);
    chk("load_a5", 32'(q_o), 32'hA5);
    chk("load_busy", 32'(bc), 32'd0);
    do_op(3'd0, 8'h00, 4'd0, 1'b0, 1'b0, bc);
    chk("nop_hold", 32'(q_o), 32'hA5);

    // SHL 3 with sin=1.
    do_op(3'd3, 8'h00, 4'd3, 1'b1, 1'b0, bc);
    chk("shl3_q", 32'(q_o), 32'h2F);
    chk("shl3_sout", 32'(sout_o), 32'd1);
    chk("shl3_busy", 32'(bc), 32'd3);

    // ROR 4 from A5, ASR 2 from 80.
    do_op(3'd1, 8'hA5, 4'd0, 1'b0, 1'b0, bc);
    do_op(3'd6, 8'h00, 4'd4, 1'b0, 1'b0, bc);
    chk("ror4_q", 32'(q_o), 32'h5A);
    do_op(3'd1, 8'h80, 4'd0, 1'b0, 1'b0, bc);
    do_op(3'd7, 8'h00, 4'd2, 1'b0, 1'b0, bc);
    chk("asr2_q", 32'(q_o), 32'hE0);
    chk("asr2_sout", 32'(sout_o), 32'd0);

    // Requests during busy are ignored (noise), amt=0, amt > WIDTH.
    do_op(3'd1, 8'h96, 4'd0, 1'b0, 1'b0, bc);
    do_op(3'd5, 8'h00, 4'd5, 1'b0, 1'b1, bc);
    chk("rol5_busy", 32'(bc), 32'd5);
    do_op(3'd3, 8'h00, 4'd0, 1'b1, 1'b0, bc);
    chk("amt0_q", 32'(q_o), 32'(m_q));
    chk("amt0_busy", 32'(bc), 32'd0);
    do_op(3'd1, 8'hFF, 4'd0, 1'b0, 1'b0, bc);
    do_op(3'd3, 8'h00, 4'd9, 1'b0, 1'b0, bc);
    chk("shl9_q", 32'(q_o), 32'h00);
    chk("shl9_busy", 32'(bc), 32'd9);

    // Reset in the 2nd busy cycle of SHR 5.
    do_op(3'd1, 8'hC3, 4'd0, 1'b0, 1'b0, bc);
    @(negedge clk);
    start_i = 1'b1; op_i = 3'd4; amt_i = 4'd5; sin_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("shr5_busy1", 32'(busy_o), 32'd1);
    @(posedge clk); #2;
    rst = 1'b1; #1;
    chk("midrun_rst_q", 32'(q_o), 32'h00);
    chk("midrun_rst_busy", 32'(busy_o), 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("midrun_no_done", 32'(done_o), 32'd0);
    end
    do_op(3'd1, 8'h11, 4'd0, 1'b0, 1'b0, bc);
    chk("load_11", 32'(q_o), 32'h11);

    // Random operations, checked cycle by cycle against the model.
    for (int i = 0; i < 200; i++) begin
      do_op(3'($urandom), 8'($urandom), 4'($urandom), 1'($urandom_range(0, 1)), 1'b1, bc);
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
